// File: rtl/rr_arbiter4_ctl_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter4_ctl_if;
    logic       EN;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] GNT_IDX;
    logic       GNT_VALID;

    modport master (output EN, REQ, input GNT, GNT_IDX, GNT_VALID);
    modport slave  (input EN, REQ, output GNT, GNT_IDX, GNT_VALID);
endinterface

// File: rtl/rr_arbiter4_ctl.sv
// Four-way round-robin arbiter with grant hold, hold-time limit and optional
// idle gap between grants; GNT/GNT_IDX/GNT_VALID all come straight from flops.
module rr_arbiter4_ctl #(
    parameter int unsigned MAX_HOLD = 8,
    parameter bit          GAP_EN   = 1'b0
) (
    input logic              CLK,
    input logic              RESETN,
    rr_arbiter4_ctl_if.slave bus
);
    localparam int unsigned   HW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [3:0]    others;
    logic          timeout;
    logic          rel;
    logic [1:0]    ptr_nx;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Scan from ptr+3 down to ptr so the last hit is the highest-priority one.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] cand;
        pick = '0;
        for (int unsigned k = 4; k > 0; k--) begin
            cand = ptr + 2'(k - 1);
            if (req[cand]) pick = cand;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        hold_d  = hold_q;

        others  = bus.REQ & ~onehot(idx_q);
        timeout = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others);
        rel     = !bus.REQ[idx_q] || timeout;
        ptr_nx  = idx_q + 2'd1;

        case (state_q)
            BUSY: begin
                if (!rel) begin
                    if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) hold_d = hold_q + 1'b1;
                end else begin
                    ptr_d = ptr_nx;
                    if (!GAP_EN && bus.EN && (|bus.REQ)) begin
                        idx_d   = pick(bus.REQ, ptr_nx);
                        gnt_d   = onehot(idx_d);
                        valid_d = 1'b1;
                        hold_d  = HW'(1);
                    end else begin
                        idx_d   = '0;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                        state_d = GAP_EN ? GAP : IDLE;
                    end
                end
            end
            default: begin
                // GAP has already spent its one idle cycle, so it arbitrates like IDLE.
                if (bus.EN && (|bus.REQ)) begin
                    idx_d   = pick(bus.REQ, ptr_q);
                    gnt_d   = onehot(idx_d);
                    valid_d = 1'b1;
                    hold_d  = HW'(1);
                    state_d = BUSY;
                end else begin
                    idx_d   = '0;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.GNT_IDX   = idx_q;
    assign bus.GNT_VALID = valid_q;
endmodule
